// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional DIV_BY_ZERO_FLAG_EN: divisor 0 short-circuits to DONE and raises dbz.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

  // Trial subtraction as R' + ~D + 1; a set top bit means R' < D, so restore.
  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial   = r_shift + ~{1'b0, d_q} + {{WIDTH{1'b0}}, 1'b1};
  assign r_step  = trial[WIDTH] ? r_shift : trial;
  assign q_step  = {q_q[WIDTH-2:0], ~trial[WIDTH]};

`ifdef DIV_BY_ZERO_FLAG_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIV_BY_ZERO_FLAG_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = CW'(WIDTH);
          quo_d   = '0;
          rem_d   = '0;
          state_d = RUN;
`ifdef DIV_BY_ZERO_FLAG_EN
          dbz_d   = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = q_step;
          rem_d   = r_step[WIDTH-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV_BY_ZERO_FLAG_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef DIV_BY_ZERO_FLAG_EN
  assign dbz       = dbz_q;
`else
  assign dbz       = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=4), sampling on the falling edge.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       dbz;

  int checks = 0;
  int passes = 0;

  seq_restoring_divider #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Issues one start pulse in cycle 0 and checks every cycle through done plus one.
  task automatic run_op(input int a, input int b, input int eq, input int er,
                        input int lat, input int edbz);
    dividend = 4'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      tick();
      start = 1'b0;
      check($sformatf("%0d/%0d busy c%0d", a, b, c), int'(busy), int'(c < lat));
      check($sformatf("%0d/%0d done c%0d", a, b, c), int'(done), int'(c == lat));
    end
    check($sformatf("%0d/%0d quotient", a, b), int'(quotient), eq);
    check($sformatf("%0d/%0d remainder", a, b), int'(remainder), er);
    check($sformatf("%0d/%0d dbz", a, b), int'(dbz), edbz);
    $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d", a, b, quotient, remainder, dbz);
    tick();
    check($sformatf("%0d/%0d done low after", a, b), int'(done), 0);
    check($sformatf("%0d/%0d q held", a, b), int'(quotient), eq);
    check($sformatf("%0d/%0d r held", a, b), int'(remainder), er);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset dbz", int'(dbz), 0);
    $display("reset state checked");

    run_op(13, 3, 4, 1, 5, 0);
    run_op(15, 1, 15, 0, 5, 0);
    run_op(3, 7, 0, 3, 5, 0);
    run_op(15, 15, 1, 0, 5, 0);
    run_op(0, 5, 0, 0, 5, 0);
`ifdef DIV_BY_ZERO_FLAG_EN
    run_op(9, 0, 15, 9, 1, 1);
`else
    run_op(9, 0, 15, 9, 5, 0);
`endif

    // A start while busy must not disturb the operation in flight.
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(); dividend = 4'd6; divisor = 4'd2; start = 1'b1;
    tick(); start = 1'b0;
    check("ignore busy c3", int'(busy), 1);
    tick(); tick();
    check("ignore done c5", int'(done), 1);
    check("ignore quotient", int'(quotient), 4);
    check("ignore remainder", int'(remainder), 1);
    $display("ignored start: q=%0d r=%0d", quotient, remainder);
    tick();

    // Reset mid-operation discards the result and emits no done.
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst quotient", int'(quotient), 0);
    check("midrst remainder", int'(remainder), 0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("midrst no done %0d", c), int'(done), 0);
    end
    $display("mid-operation reset checked");
    run_op(6, 2, 3, 0, 5, 0);

    // Start held high: results every WIDTH+1 cycles, operands swapped in DONE.
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("b2b done c%0d", c), int'(done), int'(c == 5 || c == 10));
      if (c == 5) begin
        check("b2b q1", int'(quotient), 4);
        check("b2b r1", int'(remainder), 1);
        $display("b2b result1 q=%0d r=%0d", quotient, remainder);
        dividend = 4'd6; divisor = 4'd4;
      end
      if (c == 10) begin
        check("b2b q2", int'(quotient), 1);
        check("b2b r2", int'(remainder), 2);
        $display("b2b result2 q=%0d r=%0d", quotient, remainder);
        start = 1'b0;
      end
    end
    tick();
    check("b2b idle after", int'(busy), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
